knn_dist_engine: RTL and testbench
==================================

// Module: knn_dist_engine
// PURPOSE
//  Producer side of the k-NN list interface: streams training points, computes the squared
//  Euclidean distance of each to a latched 2-D test point, and drives dist_entry/en_list into knn_list.
//  Sits between the training-data memory/stream and the knn_list bank; one test point per run.
// PARAMETERS
//  COORD_W    16   signed coordinate width (x and y)
//  DATA_W     32   distance width; must match knn_list DATA_W
//  LABEL_W    8    class label width carried alongside each distance
//  CNT_W      16   width of the training-point counter and num_points
// PORTS
//  clk          in   1        system clock, rising edge
//  rst          in   1        asynchronous, active-high reset
//  start        in   1        1-cycle pulse: latch test point and num_points, begin run
//  num_points   in   CNT_W    training points in this run (0 allowed)
//  test_x       in   COORD_W  test point x, signed, sampled on start
//  test_y       in   COORD_W  test point y, signed, sampled on start
//  train_valid  in   1        training point present on train_x/train_y/train_label
//  train_ready  out  1        engine accepts a training point this cycle
//  train_x      in   COORD_W  training point x, signed
//  train_y      in   COORD_W  training point y, signed
//  train_label  in   LABEL_W  training point class
//  en_list      out  1        1-cycle strobe: dist_entry/dist_label valid for knn_list
//  dist_entry   out  DATA_W   squared distance, saturated
//  dist_label   out  LABEL_W  label of the point that produced dist_entry
//  busy         out  1        run in progress (RUN or FLUSH)
//  done         out  1        1-cycle pulse: last distance of the run has been emitted
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; pipeline valid bits, counters, latched test point cleared.
//  FSM: IDLE -start-> RUN (num_points!=0) | DONE (num_points==0).
//       RUN: accept on train_valid&train_ready; count accepts; after accept #num_points -> FLUSH.
//       FLUSH: wait until all pipeline valid bits are 0 -> DONE. DONE: done=1 one cycle -> IDLE.
//  train_ready = (state==RUN) & (accepted < num_points); combinational from state/count only,
//       never from train_valid. No backpressure from knn_list: en_list is never stalled.
//  Pipeline, 3 stages, one point/cycle throughput:
//   S1: dx = train_x - test_x, dy = train_y - test_y, each COORD_W+1 bits signed (no overflow).
//   S2: sx = dx*dx, sy = dy*dy, each 2*COORD_W+2 bits unsigned.
//   S3: sum = sx+sy; dist_entry = (sum >= 2**DATA_W) ? {DATA_W{1'b1}} : sum[DATA_W-1:0].
//  Latency: point accepted at edge n -> en_list=1 with its dist_entry/dist_label in cycle n+3.
//  Label rides the pipeline with its point; en_list is the S3 valid bit, high exactly 1 cycle/point.
//  dist_entry/dist_label hold last value when en_list=0.
//  done asserts the cycle after the final en_list (in DONE); num_points==0: done the cycle
//       after start, no en_list.
//  busy=1 in RUN and FLUSH; 0 in IDLE and DONE.
//  start while not IDLE: ignored (test point and num_points not re-latched).
//  start and train_valid together in IDLE: point not accepted (train_ready=0 in IDLE).
//  Counter saturation impossible: accepted counts to num_points <= 2**CNT_W-1.
//  Reset mid-run: in-flight points dropped, no en_list or done after reset deasserts.
// STRUCTURE
//  Shared header knn_defs.vh: COORD_W, DATA_W, LABEL_W defaults, DIST_MAX={DATA_W{1'b1}},
//       FSM state encodings (IDLE=2'd0, RUN=2'd1, FLUSH=2'd2, DONE=2'd3).
//  Sub-module knn_sqdiff (instantiated twice, x and y): registered subtract then registered square,
//       with valid pass-through; top holds FSM, counter, label pipe, S3 adder/saturation.
// TESTING
//  1: test=(0,0), num=3, points (3,4,L1),(1,1,L2),(0,0,L3) back-to-back -> en_list 3 cycles,
//     dist_entry 25,2,0 with labels 1,2,3; first at accept+3; done cycle after last.
//  2: test=(-32768,-32768), point (32767,32767) -> sum 2*65535^2 > 2^32-1 -> dist_entry=32'hFFFFFFFF.
//  3: test=(10,-5), point (-10,5), train_valid toggling 1/0 -> dist 500, en_list only for
//     accepted points, order preserved.
//  4: num_points=0 start -> done 1 cycle later, busy never 1, no en_list.
//  5: start pulsed during RUN with different test point -> ignored; distances use first test point.
//  6: rst asserted 1 cycle after 2 accepts -> outputs 0 immediately, no en_list/done after release;
//     new start then runs normally.

Source files
------------

// File: rtl/knn_dist_engine_pkg.sv
// Shared types and defaults for the k-NN distance engine: widths and the run-control state encoding.
package knn_dist_engine_pkg;

    localparam int COORD_W_DEF = 16;
    localparam int DATA_W_DEF  = 32;
    localparam int LABEL_W_DEF = 8;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic is_busy(input state_e s);
        return (s == ST_RUN) || (s == ST_FLUSH);
    endfunction

endpackage

// File: rtl/knn_dist_engine_if.sv
// Training-point stream into the distance engine: valid/ready handshake plus point and label.
interface knn_dist_engine_if
    import knn_dist_engine_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int LABEL_W = LABEL_W_DEF
) ();

    logic                      train_valid;
    logic                      train_ready;
    logic signed [COORD_W-1:0] train_x;
    logic signed [COORD_W-1:0] train_y;
    logic [LABEL_W-1:0]        train_label;

    modport master (
        output train_valid,
        output train_x,
        output train_y,
        output train_label,
        input  train_ready
    );

    modport slave (
        input  train_valid,
        input  train_x,
        input  train_y,
        input  train_label,
        output train_ready
    );

endinterface

// File: rtl/knn_dist_engine_sqdiff.sv
// Two-stage squared difference (a-b)^2: registered widened subtract, then registered square.
module knn_dist_engine_sqdiff #(
    parameter int COORD_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic signed [COORD_W-1:0] a,
    input  logic signed [COORD_W-1:0] b,
    output logic                      valid_s1,
    output logic                      valid_s2,
    output logic [2*COORD_W+1:0]      sq
);

    localparam int SQ_W = 2*COORD_W + 2;

    logic signed [COORD_W:0] diff_r;
    logic signed [SQ_W-1:0]  dext_s;
    logic signed [SQ_W-1:0]  prod_s;
    logic [SQ_W-1:0]         sq_r;
    logic                    v1_r;
    logic                    v2_r;

    // One extra bit on the difference keeps the full signed range; the square is non-negative.
    assign dext_s = SQ_W'(diff_r);
    assign prod_s = dext_s * dext_s;

    // Subtract stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_r <= '0;
            v1_r   <= 1'b0;
        end else begin
            v1_r <= in_valid;
            if (in_valid) begin
                diff_r <= {a[COORD_W-1], a} - {b[COORD_W-1], b};
            end
        end
    end

    // Square stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq_r <= '0;
            v2_r <= 1'b0;
        end else begin
            v2_r <= v1_r;
            if (v1_r) begin
                sq_r <= $unsigned(prod_s);
            end
        end
    end

    assign valid_s1 = v1_r;
    assign valid_s2 = v2_r;
    assign sq       = sq_r;

endmodule

// File: rtl/knn_dist_engine.sv
// k-NN producer: streams training points, computes saturated squared distance to a latched
// test point through a 3-stage pipeline and strobes each result toward the knn_list bank.
module knn_dist_engine
    import knn_dist_engine_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LABEL_W = LABEL_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [CNT_W-1:0]          num_points,
    input  logic signed [COORD_W-1:0] test_x,
    input  logic signed [COORD_W-1:0] test_y,
    knn_dist_engine_if.slave          train,
    output logic                      en_list,
    output logic [DATA_W-1:0]         dist_entry,
    output logic [LABEL_W-1:0]        dist_label,
    output logic                      busy,
    output logic                      done
);

    localparam int SQ_W  = 2*COORD_W + 2;
    localparam int SUM_W = SQ_W + 1;

    state_e                    state_r;
    state_e                    state_s;
    logic [CNT_W-1:0]          num_r;
    logic [CNT_W-1:0]          accepted_r;
    logic signed [COORD_W-1:0] test_x_r;
    logic signed [COORD_W-1:0] test_y_r;
    logic [LABEL_W-1:0]        lab1_r;
    logic [LABEL_W-1:0]        lab2_r;

    logic                      ready_s;
    logic                      accept_s;
    logic                      last_accept_s;
    logic                      start_idle_s;
    logic                      vx1_s;
    logic                      vx2_s;
    logic                      vy1_s;
    logic                      vy2_s;
    logic                      s3_valid_s;
    logic                      pipe_busy_s;
    logic [SQ_W-1:0]           sqx_s;
    logic [SQ_W-1:0]           sqy_s;
    logic [SUM_W-1:0]          sum_s;

    function automatic logic [DATA_W-1:0] saturate(input logic [SUM_W-1:0] s);
        logic [DATA_W-1:0] res;
        if ((s >> DATA_W) != '0) begin
            res = {DATA_W{1'b1}};
        end else begin
            res = DATA_W'(s);
        end
        return res;
    endfunction

    // Ready depends only on state and count so the producer never sees a valid->ready loop.
    assign ready_s       = (state_r == ST_RUN) && (accepted_r < num_r);
    assign accept_s      = ready_s && train.train_valid;
    assign last_accept_s = accept_s && ((accepted_r + CNT_W'(1)) == num_r);
    assign start_idle_s  = start && (state_r == ST_IDLE);
    assign train.train_ready = ready_s;

    // Stages still ahead of the output register; once clear, the final strobe is in flight.
    assign pipe_busy_s = vx1_s | vx2_s | vy1_s | vy2_s;
    assign s3_valid_s  = vx2_s & vy2_s;
    assign sum_s       = {1'b0, sqx_s} + {1'b0, sqy_s};

    knn_dist_engine_sqdiff #(.COORD_W(COORD_W)) u_sqdiff_x (
        .clk      (clk),
        .rst      (rst),
        .in_valid (accept_s),
        .a        (train.train_x),
        .b        (test_x_r),
        .valid_s1 (vx1_s),
        .valid_s2 (vx2_s),
        .sq       (sqx_s)
    );

    knn_dist_engine_sqdiff #(.COORD_W(COORD_W)) u_sqdiff_y (
        .clk      (clk),
        .rst      (rst),
        .in_valid (accept_s),
        .a        (train.train_y),
        .b        (test_y_r),
        .valid_s1 (vy1_s),
        .valid_s2 (vy2_s),
        .sq       (sqy_s)
    );

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = (num_points == {CNT_W{1'b0}}) ? ST_DONE : ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_accept_s) begin
                    state_s = ST_FLUSH;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (!pipe_busy_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_FLUSH;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Run parameters are latched only from IDLE; a stray start mid-run leaves them untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_r      <= {CNT_W{1'b0}};
            accepted_r <= {CNT_W{1'b0}};
            test_x_r   <= '0;
            test_y_r   <= '0;
        end else if (start_idle_s) begin
            num_r      <= num_points;
            accepted_r <= {CNT_W{1'b0}};
            test_x_r   <= test_x;
            test_y_r   <= test_y;
        end else if (accept_s) begin
            accepted_r <= accepted_r + CNT_W'(1);
        end
    end

    // Label pipe tracking the two sqdiff stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lab1_r <= {LABEL_W{1'b0}};
            lab2_r <= {LABEL_W{1'b0}};
        end else begin
            if (accept_s) begin
                lab1_r <= train.train_label;
            end
            if (vx1_s) begin
                lab2_r <= lab1_r;
            end
        end
    end

    // Sum/saturate stage; data holds its last value between strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_list    <= 1'b0;
            dist_entry <= {DATA_W{1'b0}};
            dist_label <= {LABEL_W{1'b0}};
        end else begin
            en_list <= s3_valid_s;
            if (s3_valid_s) begin
                dist_entry <= saturate(sum_s);
                dist_label <= lab2_r;
            end
        end
    end

    // Status outputs registered from the next state so they line up with the state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= is_busy(state_s);
            done <= (state_s == ST_DONE);
        end
    end

endmodule

// File: tb/tb_knn_dist_engine.sv
// Directed bench for knn_dist_engine: inputs change and outputs are checked on the falling edge.
module tb_knn_dist_engine;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [15:0]        num_points;
    logic signed [15:0] test_x;
    logic signed [15:0] test_y;
    logic               en_list;
    logic [31:0]        dist_entry;
    logic [7:0]         dist_label;
    logic               busy;
    logic               done;
    int                 compared   = 0;
    int                 mismatched = 0;

    always #5 clk = ~clk;

    knn_dist_engine_if #(.COORD_W(16), .LABEL_W(8)) tif ();

    knn_dist_engine #(.COORD_W(16), .DATA_W(32), .LABEL_W(8), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_points (num_points),
        .test_x     (test_x),
        .test_y     (test_y),
        .train      (tif),
        .en_list    (en_list),
        .dist_entry (dist_entry),
        .dist_label (dist_label),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic out_chk(input string tag, input logic en, input logic [31:0] d, input logic [7:0] l);
        check({tag, ".en"},    {63'd0, en_list}, {63'd0, en});
        check({tag, ".dist"},  {32'd0, dist_entry}, {32'd0, d});
        check({tag, ".label"}, {56'd0, dist_label}, {56'd0, l});
    endtask

    task automatic status_chk(input string tag, input logic b, input logic d);
        check({tag, ".busy"}, {63'd0, busy}, {63'd0, b});
        check({tag, ".done"}, {63'd0, done}, {63'd0, d});
    endtask

    task automatic pt(input logic v, input logic signed [15:0] x, input logic signed [15:0] y,
                      input logic [7:0] l);
        tif.train_valid = v;
        tif.train_x     = x;
        tif.train_y     = y;
        tif.train_label = l;
    endtask

    task automatic run_start(input logic [15:0] n, input logic signed [15:0] x, input logic signed [15:0] y);
        start      = 1'b1;
        num_points = n;
        test_x     = x;
        test_y     = y;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; num_points = 16'd0; test_x = 16'sd0; test_y = 16'sd0;
        pt(1'b0, 16'sd0, 16'sd0, 8'd0);
        nxt(); nxt();
        out_chk("rst", 1'b0, 32'd0, 8'd0);
        status_chk("rst", 1'b0, 1'b0);
        check("rst.ready", {63'd0, tif.train_ready}, 64'd0);
        rst = 1'b0;

        // 1: three back-to-back points against the origin
        nxt(); run_start(16'd3, 16'sd0, 16'sd0);
        pt(1'b1, 16'sd9, 16'sd9, 8'd9);      // present in IDLE, must not be taken
        nxt(); start = 1'b0;
        status_chk("t1.run", 1'b1, 1'b0);
        check("t1.ready", {63'd0, tif.train_ready}, 64'd1);
        pt(1'b1, 16'sd3, 16'sd4, 8'd1);
        nxt(); check("t1.lat0", {63'd0, en_list}, 64'd0); pt(1'b1, 16'sd1, 16'sd1, 8'd2);
        nxt(); check("t1.lat1", {63'd0, en_list}, 64'd0); pt(1'b1, 16'sd0, 16'sd0, 8'd3);
        nxt(); out_chk("t1.p1", 1'b1, 32'd25, 8'd1);
        check("t1.ready0", {63'd0, tif.train_ready}, 64'd0);
        pt(1'b0, 16'sd0, 16'sd0, 8'd0);
        nxt(); out_chk("t1.p2", 1'b1, 32'd2, 8'd2);
        nxt(); out_chk("t1.p3", 1'b1, 32'd0, 8'd3); status_chk("t1.flush", 1'b1, 1'b0);
        nxt(); out_chk("t1.hold", 1'b0, 32'd0, 8'd3); status_chk("t1.done", 1'b0, 1'b1);
        nxt(); status_chk("t1.idle", 1'b0, 1'b0);

        // 2: saturation at the extreme corners
        nxt(); run_start(16'd1, -16'sd32768, -16'sd32768);
        nxt(); start = 1'b0; pt(1'b1, 16'sd32767, 16'sd32767, 8'hAA);
        nxt(); pt(1'b0, 16'sd0, 16'sd0, 8'd0); check("t2.lat0", {63'd0, en_list}, 64'd0);
        nxt(); check("t2.lat1", {63'd0, en_list}, 64'd0);
        nxt(); out_chk("t2.sat", 1'b1, 32'hFFFF_FFFF, 8'hAA); status_chk("t2.pre", 1'b1, 1'b0);
        nxt(); status_chk("t2.done", 1'b0, 1'b1); check("t2.en", {63'd0, en_list}, 64'd0);

        // 3: gapped valid, negative coordinates
        nxt(); run_start(16'd3, 16'sd10, -16'sd5);
        nxt(); start = 1'b0; pt(1'b1, -16'sd10, 16'sd5, 8'd4);
        nxt(); pt(1'b0, -16'sd10, 16'sd5, 8'd0); check("t3.e0", {63'd0, en_list}, 64'd0);
        nxt(); pt(1'b1, -16'sd10, 16'sd5, 8'd5); check("t3.e1", {63'd0, en_list}, 64'd0);
        nxt(); pt(1'b0, -16'sd10, 16'sd5, 8'd0); out_chk("t3.p1", 1'b1, 32'd500, 8'd4);
        nxt(); pt(1'b1, -16'sd10, 16'sd5, 8'd6); out_chk("t3.gap1", 1'b0, 32'd500, 8'd4);
        nxt(); pt(1'b0, 16'sd0, 16'sd0, 8'd0); out_chk("t3.p2", 1'b1, 32'd500, 8'd5);
        nxt(); out_chk("t3.gap2", 1'b0, 32'd500, 8'd5);
        nxt(); out_chk("t3.p3", 1'b1, 32'd500, 8'd6);
        nxt(); status_chk("t3.done", 1'b0, 1'b1);

        // 4: empty run
        nxt(); run_start(16'd0, 16'sd1, 16'sd1);
        nxt(); start = 1'b0;
        status_chk("t4.done", 1'b0, 1'b1); check("t4.en", {63'd0, en_list}, 64'd0);
        nxt(); status_chk("t4.after", 1'b0, 1'b0); check("t4.en2", {63'd0, en_list}, 64'd0);

        // 5: start during RUN must not re-latch test point or count
        nxt(); run_start(16'd2, 16'sd0, 16'sd0);
        nxt(); run_start(16'd5, 16'sd100, 16'sd100); pt(1'b1, 16'sd1, 16'sd2, 8'd7);
        nxt(); start = 1'b0; pt(1'b1, 16'sd2, 16'sd2, 8'd8);
        nxt(); pt(1'b0, 16'sd0, 16'sd0, 8'd0);
        check("t5.ready0", {63'd0, tif.train_ready}, 64'd0); status_chk("t5.run", 1'b1, 1'b0);
        nxt(); out_chk("t5.p1", 1'b1, 32'd5, 8'd7);
        nxt(); out_chk("t5.p2", 1'b1, 32'd8, 8'd8);
        nxt(); status_chk("t5.done", 1'b0, 1'b1);

        // 6: reset mid-run drops in-flight points
        nxt(); run_start(16'd4, 16'sd0, 16'sd0);
        nxt(); start = 1'b0; pt(1'b1, 16'sd1, 16'sd0, 8'd9);
        nxt(); pt(1'b1, 16'sd0, 16'sd2, 8'd10);
        nxt(); pt(1'b0, 16'sd0, 16'sd0, 8'd0); rst = 1'b1;
        #1;
        out_chk("t6.rst", 1'b0, 32'd0, 8'd0); status_chk("t6.rst", 1'b0, 1'b0);
        check("t6.ready", {63'd0, tif.train_ready}, 64'd0);
        nxt(); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nxt();
            check("t6.quiet.en", {63'd0, en_list}, 64'd0);
            check("t6.quiet.done", {63'd0, done}, 64'd0);
        end
        run_start(16'd1, 16'sd0, 16'sd0);
        nxt(); start = 1'b0; pt(1'b1, 16'sd2, 16'sd3, 8'd11);
        nxt(); pt(1'b0, 16'sd0, 16'sd0, 8'd0);
        nxt(); check("t6.lat", {63'd0, en_list}, 64'd0);
        nxt(); out_chk("t6.p1", 1'b1, 32'd13, 8'd11);
        nxt(); status_chk("t6.done", 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
